// File: rtl/i2c_register_target.sv
// i2c_register_target: I2C/SCCB register target with a 16-bit auto-incrementing pointer.
// Ports:
//   clk_camera, sys_rst_camera : system clock (>=16x SCL), synchronous active-low reset
//   scl_i, sda_i               : raw bus inputs from the IOBUF pair
//   sda_o, sda_t               : open-drain SDA drive (sda_o fixed 0, sda_t=1 releases)
//   wr_valid/wr_addr/wr_data   : one-cycle pulse per received data byte
//   rd_req/rd_addr, rd_data    : read request pulse; rd_data valid one cycle after rd_req
//   busy                       : high from an addressed START until STOP
module i2c_register_target #(
  parameter logic [6:0] DEVICE_ADDR = 7'h3C
) (
  input  logic        clk_camera,
  input  logic        sys_rst_camera,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_o,
  output logic        sda_t,
  output logic        wr_valid,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        rd_req,
  output logic [15:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic        busy
);
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 3;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ACK_ADDR, S_REG_HI, S_ACK_HI, S_REG_LO, S_ACK_LO,
    S_WR_DATA, S_ACK_WR, S_RD_DATA, S_RD_ACK, S_IGNORE
  } state_t;

  state_t        state_q, state_d;
  logic          scl_s1_q, scl_s2_q, scl_h_q;
  logic          sda_s1_q, sda_s2_q, sda_h_q;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DW-1:0] shift_q, shift_d;
  logic          done_q, done_d;
  logic          ld_q, ld_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          sda_t_q, sda_t_d;
  logic          wr_valid_q, wr_valid_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          rd_req_q, rd_req_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          busy_q, busy_d;

  logic          scl_rise, scl_fall, start_det, stop_det;
  logic [DW-1:0] byte_in;

  // Edge and bus-condition detection on synchronized values.
  assign scl_rise  = scl_s2_q & ~scl_h_q;
  assign scl_fall  = ~scl_s2_q & scl_h_q;
  assign start_det = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
  assign byte_in   = {shift_q[DW-2:0], sda_s2_q};

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    done_d     = done_q;
    ld_d       = rd_req_q;
    ptr_d      = ptr_q;
    sda_t_d    = sda_t_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_req_d   = 1'b0;
    rd_addr_d  = rd_addr_q;
    busy_d     = busy_q;

    if (start_det) begin
      state_d   = S_ADDR;
      bit_cnt_d = '0;
      done_d    = 1'b0;
      sda_t_d   = 1'b1;
    end else if (stop_det) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      sda_t_d = 1'b1;
      busy_d  = 1'b0;
    end else begin
      // Read byte arrives one cycle after rd_req; drive its MSB immediately.
      if (ld_q && state_q == S_RD_DATA) begin
        shift_d = rd_data;
        sda_t_d = rd_data[DW-1];
      end
      if (scl_rise) begin
        case (state_q)
          S_ADDR, S_REG_HI, S_REG_LO, S_WR_DATA: begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + CW'(1);
            if (bit_cnt_q == CW'(7)) begin
              done_d = 1'b1;
              if (state_q == S_REG_HI) ptr_d[15:8] = byte_in;
              if (state_q == S_REG_LO) ptr_d[7:0]  = byte_in;
              if (state_q == S_WR_DATA) begin
                wr_valid_d = 1'b1;
                wr_addr_d  = ptr_q;
                wr_data_d  = byte_in;
                ptr_d      = ptr_q + AW'(1);
              end
            end
          end
          S_RD_DATA: begin
            bit_cnt_d = bit_cnt_q + CW'(1);
            if (bit_cnt_q == CW'(7)) done_d = 1'b1;
          end
          S_RD_ACK: begin
            if (sda_s2_q) begin
              state_d = S_IGNORE;
            end else begin
              ptr_d  = ptr_q + AW'(1);
              done_d = 1'b1;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state_q)
          S_ADDR: begin
            if (done_q) begin
              done_d = 1'b0;
              if (shift_q[7:1] == DEVICE_ADDR) begin
                state_d = S_ACK_ADDR;
                busy_d  = 1'b1;
                sda_t_d = 1'b0;
              end else begin
                state_d = S_IGNORE;
              end
            end
          end
          S_REG_HI, S_REG_LO, S_WR_DATA: begin
            if (done_q) begin
              done_d  = 1'b0;
              sda_t_d = 1'b0;
              state_d = (state_q == S_REG_HI) ? S_ACK_HI :
                        (state_q == S_REG_LO) ? S_ACK_LO : S_ACK_WR;
            end
          end
          S_ACK_ADDR: begin
            sda_t_d = 1'b1;
            // shift_q still holds the address byte; bit 0 is R/W.
            if (shift_q[0]) begin
              state_d   = S_RD_DATA;
              rd_req_d  = 1'b1;
              rd_addr_d = ptr_q;
            end else begin
              state_d = S_REG_HI;
            end
          end
          S_ACK_HI: begin
            sda_t_d = 1'b1;
            state_d = S_REG_LO;
          end
          S_ACK_LO, S_ACK_WR: begin
            sda_t_d = 1'b1;
            state_d = S_WR_DATA;
          end
          S_RD_DATA: begin
            if (done_q) begin
              done_d  = 1'b0;
              sda_t_d = 1'b1;
              state_d = S_RD_ACK;
            end else begin
              shift_d = {shift_q[DW-2:0], 1'b0};
              sda_t_d = shift_q[DW-2];
            end
          end
          S_RD_ACK: begin
            if (done_q) begin
              done_d    = 1'b0;
              state_d   = S_RD_DATA;
              rd_req_d  = 1'b1;
              rd_addr_d = ptr_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // State registers; synchronizers reset to the idle-bus level to avoid false edges.
  always_ff @(posedge clk_camera) begin
    if (!sys_rst_camera) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_h_q    <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_h_q    <= 1'b1;
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      done_q     <= 1'b0;
      ld_q       <= 1'b0;
      ptr_q      <= '0;
      sda_t_q    <= 1'b1;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      scl_s1_q   <= scl_i;
      scl_s2_q   <= scl_s1_q;
      scl_h_q    <= scl_s2_q;
      sda_s1_q   <= sda_i;
      sda_s2_q   <= sda_s1_q;
      sda_h_q    <= sda_s2_q;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      done_q     <= done_d;
      ld_q       <= ld_d;
      ptr_q      <= ptr_d;
      sda_t_q    <= sda_t_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_req_q   <= rd_req_d;
      rd_addr_q  <= rd_addr_d;
      busy_q     <= busy_d;
    end
  end

  assign sda_o    = 1'b0;
  assign sda_t    = sda_t_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rd_req   = rd_req_q;
  assign rd_addr  = rd_addr_q;
  assign busy     = busy_q;
endmodule

// File: doc/i2c_register_target.md
# i2c_register_target

I2C/SCCB target (slave) that answers the camera-configuration master's register transactions. It decodes writes of the form device address, 16-bit register address, then data bytes, and serves reads from the same pointer. It sits on the camera I2C bus behind the IOBUF pair, wherever a configuration target is needed. Typical uses are a loopback bench target for the configurator and an on-FPGA register bank driven over SCCB. It owns open-drain SDA only; SCL is input-only, with no clock stretching.

## Interface
- DEVICE_ADDR, 7'h3C: 7-bit target address matched against the first byte.
- clk_camera  in  1  system clock; must be ≥16× the SCL frequency.
- sys_rst_camera  in  1  synchronous, active-low reset.
- scl_i  in  1  raw SCL from IOBUF.
- sda_i  in  1  raw SDA from IOBUF.
- sda_o  out  1  SDA drive value; always 0.
- sda_t  out  1  SDA tristate: 1 = release, 0 = pull low.
- wr_valid  out  1  one-cycle pulse; a data byte was received.
- wr_addr  out  16  register address for wr_valid.
- wr_data  out  8  data byte for wr_valid.
- rd_req  out  1  one-cycle pulse; requests the byte at rd_addr.
- rd_addr  out  16  register address for rd_req.
- rd_data  in  8  read data; must be valid exactly 1 cycle after rd_req.
- busy  out  1  high from an addressed START until STOP.

## Operation
- **Input conditioning:** scl_i and sda_i each pass through a 2-flop synchronizer, then a 1-flop history register. All decisions use the synchronized values and their edges.
- **START:** SDA falls while SCL is high. Taken from any state, so repeated START is supported. Clears the bit counter and enters ADDR.
- **STOP:** SDA rises while SCL is high. Taken from any state; enters IDLE, releases SDA and clears busy.
- **Bit sampling and driving:** SDA is sampled on the synchronized SCL rise. SDA drive changes only on the synchronized SCL fall. The bit counter runs 0..7, MSB first.
- **FSM states:** IDLE, ADDR, ACK_ADDR, REG_HI, ACK_HI, REG_LO, ACK_LO, WR_DATA, ACK_WR, RD_DATA, RD_ACK, IGNORE.
- **ADDR:** after 8 bits, if byte[7:1] == DEVICE_ADDR, go to ACK_ADDR and set busy. On a mismatch go to IGNORE, with SDA released until the next START or STOP.
- **ACK states (ACK_ADDR, ACK_HI, ACK_LO, ACK_WR):**
  - sda_t goes to 0 on the SCL fall after bit 7.
  - sda_t returns to 1 on the next SCL fall, which ends the 9th clock.
  - On that same fall the FSM moves to the next state.
- **Next state after ACK_ADDR:** R/W=0 goes to REG_HI; R/W=1 goes to RD_DATA.
- **Write path:**
  - REG_HI loads ptr[15:8]; REG_LO loads ptr[7:0]; then WR_DATA.
  - Each completed WR_DATA byte produces wr_valid with wr_addr=ptr and wr_data=byte, then ptr increments; the FSM goes to ACK_WR and back to WR_DATA.
  - Any number of data bytes per transaction is accepted, including zero (pointer-set only).
- **Read path:**
  - On entry to RD_DATA, rd_req pulses with rd_addr=ptr. rd_data is loaded into the shift register the next cycle.
  - Each bit is driven open-drain: sda_t = bit (a 1 releases, a 0 pulls low).
  - After 8 bits, release SDA and go to RD_ACK, where the master's 9th bit is sampled.
  - ACK (0): ptr increments, then RD_DATA with a new rd_req.
  - NACK (1): IGNORE.
- **Pointer:** ptr persists across transactions, so a write-pointer, repeated START, read sequence works. ptr wraps from 16'hFFFF to 16'h0000.

## Timing
- **Reset values:** sda_t=1, sda_o=0, wr_valid=0, wr_addr=0, wr_data=0, rd_req=0, rd_addr=0, busy=0, ptr=0, FSM in IDLE.
- **Edge-detect latency:** 3 cycles from raw pin to detected edge.
- **wr_valid:** asserted 1 cycle after the detected SCL rise of data bit 0 (LSB).
- **rd_req:** asserted 1 cycle after the detected SCL fall that ends the preceding ACK. The first data bit is driven 2 cycles after rd_req.
- **Simultaneous SCL-high SDA edge with START/STOP:** START/STOP takes precedence over data sampling.
- **Reset mid-transaction:** SDA is released immediately (next clock) and no wr_valid is emitted for the partial byte.
- **SDA glitches:** a glitch shorter than 1 clock after synchronization is not filtered. Bus rise time is the board's responsibility.

## Test plan
- **Single write:** START, 0x78, 0x30, 0x08, 0x42, STOP → ACK after each byte; exactly one wr_valid with wr_addr=16'h3008, wr_data=8'h42; busy falls after STOP.
- **Burst write:** 0x78, 0x43, 0x00, data 0x11, 0x22, 0x33 → three wr_valid pulses at addresses 16'h4300, 16'h4301, 16'h4302.
- **Wrong address:** 0x7A, ... → SDA never pulled low, no wr_valid, busy stays 0.
- **Pointer set, repeated START, read:** 0x78, 0x30, 0x0A, Sr, 0x79; bench returns 0x56, 0x40; master ACKs then NACKs → rd_addr 16'h300A then 16'h300B; bytes 0x56 and 0x40 seen on SDA; SDA released after NACK.
- **Wrap:** write starting at 16'hFFFF with 2 data bytes → wr_addr 16'hFFFF then 16'h0000.
- **Reset mid-byte:** reset after 4 data bits → sda_t=1 the next cycle, no wr_valid; a following full transaction works normally.
